bz_scanout: RTL and testbench



---
 rtl/bz_scanout.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_bz_scanout.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bz_scanout.sv
// bz_scanout
// ----------
// Raster scan-out stage that sits behind the VGA timing generator.
// Each active 640x480 coordinate is halved (2x pixel and line doubling) into
// a read of a double-buffered 320x240 4-bit intensity framebuffer. The
// returned intensity is coloured red for the top RED_ROWS source lines and
// green below. The sync/enable/blank sideband is delayed so that it stays
// aligned with the RGB output. The block also owns the vblank-synchronised
// bank swap handshake with the vector rasteriser.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pix_ce              one-clk pixel strobe; timing inputs are valid with it
//   row, col            active coordinate from the timing generator
//   Hsync, Vsync        active-low sync pulses
//   en_r                active-video indicator
//   hBlank, vBlank      blanking indicators
//   fb_rd, fb_addr      framebuffer read strobe and address (within bank)
//   fb_sel              bank currently being displayed
//   fb_data             read data, valid one clk after fb_rd
//   swap_req, swap_ack  bank swap request level / one-clk acknowledge
//   vga_r/g/b           colour output
//   vga_hs/vs/de/hblank/vblank  sideband aligned with the colour output
//
// Timing: fb_rd/fb_addr are driven in the same clk as the pix_ce strobe so
// that the read data arrives before the next non-strobe edge. The data is
// captured on that edge and coloured on the following pix_ce, which keeps the
// colour path in step with the two-deep sideband pipeline.
module bz_scanout #(
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int ADDR_W   = 17,
    parameter int RED_ROWS = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [8:0]        row,
    input  logic [9:0]        col,
    input  logic              Hsync,
    input  logic              Vsync,
    input  logic              en_r,
    input  logic              hBlank,
    input  logic              vBlank,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_sel,
    input  logic [3:0]        fb_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              vga_hblank,
    output logic              vga_vblank
);

    // Swap FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [31:0] FB_W_BITS = 32'(FB_W);

    // Row base address sy*FB_W built from shifted copies of sy, one per set
    // bit of FB_W (sy*256 + sy*64 for the default width), so no multiplier.
    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] ext;
        acc = '0;
        ext = ADDR_W'(y);
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_BITS[i]) begin
                acc = acc + (ext << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: address generation
    // ------------------------------------------------------------------
    logic [7:0]        sy_s;
    logic [8:0]        sx_s;
    logic [ADDR_W-1:0] addr_calc_s;
    logic              in_range_s;
    logic              red_s;
    logic              rd_s;
    logic              unused_lsb_s;

    logic [ADDR_W-1:0] addr_hold_r;
    logic              rd_d1_r;
    logic              red_d1_r;

    assign sy_s         = row[8:1];
    assign sx_s         = col[9:1];
    // Row/column LSBs only select the duplicated screen pixel.
    assign unused_lsb_s = row[0] ^ col[0];
    assign addr_calc_s  = row_base(sy_s) + ADDR_W'(sx_s);
    // Out-of-framebuffer coordinates never issue a read.
    assign in_range_s   = (32'(sy_s) < 32'(FB_H)) && (32'(sx_s) < 32'(FB_W));
    assign red_s        = (32'(sy_s) < 32'(RED_ROWS));
    // rst gates the strobe so the read port is quiet the moment reset asserts.
    assign rd_s         = pix_ce & en_r & in_range_s & ~rst;

    assign fb_rd   = rd_s;
    assign fb_addr = rd_s ? addr_calc_s : addr_hold_r;

    // Hold the last issued address and track the read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold_r <= '0;
            rd_d1_r     <= 1'b0;
            red_d1_r    <= 1'b0;
        end else begin
            rd_d1_r <= rd_s;
            if (rd_s) begin
                addr_hold_r <= addr_calc_s;
                red_d1_r    <= red_s;
            end else begin
                addr_hold_r <= addr_hold_r;
                red_d1_r    <= red_d1_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture: the read data is valid the clk after the strobe
    // ------------------------------------------------------------------
    logic [3:0] pix_i_r;
    logic       red_i_r;

    // Latch returned intensity and its colour band.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_i_r <= 4'h0;
            red_i_r <= 1'b0;
        end else if (rd_d1_r) begin
            pix_i_r <= fb_data;
            red_i_r <= red_d1_r;
        end else begin
            pix_i_r <= pix_i_r;
            red_i_r <= red_i_r;
        end
    end

    // ------------------------------------------------------------------
    // Sideband stage 1 (stage 2 is the output register set)
    // ------------------------------------------------------------------
    logic hs_d1_r;
    logic vs_d1_r;
    logic de_d1_r;
    logic hb_d1_r;
    logic vb_d1_r;

    // First sideband delay, advanced on the pixel strobe only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d1_r <= 1'b1;
            vs_d1_r <= 1'b1;
            de_d1_r <= 1'b0;
            hb_d1_r <= 1'b1;
            vb_d1_r <= 1'b1;
        end else if (pix_ce) begin
            hs_d1_r <= Hsync;
            vs_d1_r <= Vsync;
            de_d1_r <= en_r;
            hb_d1_r <= hBlank;
            vb_d1_r <= vBlank;
        end else begin
            hs_d1_r <= hs_d1_r;
            vs_d1_r <= vs_d1_r;
            de_d1_r <= de_d1_r;
            hb_d1_r <= hb_d1_r;
            vb_d1_r <= vb_d1_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: colourise
    // ------------------------------------------------------------------
    logic [3:0] r_s;
    logic [3:0] g_s;

    // Red band or green band; black whenever the delayed enable is low.
    always_comb begin
        r_s = 4'h0;
        g_s = 4'h0;
        case ({de_d1_r, red_i_r})
            2'b11:   r_s = pix_i_r;
            2'b10:   g_s = pix_i_r;
            default: begin
                r_s = 4'h0;
                g_s = 4'h0;
            end
        endcase
    end

    // Output registers: colour and second sideband delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r      <= 4'h0;
            vga_g      <= 4'h0;
            vga_b      <= 4'h0;
            vga_hs     <= 1'b1;
            vga_vs     <= 1'b1;
            vga_de     <= 1'b0;
            vga_hblank <= 1'b1;
            vga_vblank <= 1'b1;
        end else if (pix_ce) begin
            vga_r      <= r_s;
            vga_g      <= g_s;
            vga_b      <= 4'h0;
            vga_hs     <= hs_d1_r;
            vga_vs     <= vs_d1_r;
            vga_de     <= de_d1_r;
            vga_hblank <= hb_d1_r;
            vga_vblank <= vb_d1_r;
        end else begin
            vga_r      <= vga_r;
            vga_g      <= vga_g;
            vga_b      <= vga_b;
            vga_hs     <= vga_hs;
            vga_vs     <= vga_vs;
            vga_de     <= vga_de;
            vga_hblank <= vga_hblank;
            vga_vblank <= vga_vblank;
        end
    end

    // ------------------------------------------------------------------
    // Swap handshake
    // ------------------------------------------------------------------
    logic [1:0] state_r;
    logic [1:0] state_n_s;
    logic       toggle_s;
    logic       vb_rise_s;
    logic       fb_sel_r;
    logic       swap_ack_r;

    // vb_d1_r holds the previous strobe's vBlank, so this is the 0->1 edge.
    assign vb_rise_s = pix_ce & vBlank & ~vb_d1_r;

    // Next-state logic; ACK must see swap_req drop before another swap.
    always_comb begin
        state_n_s = state_r;
        toggle_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (swap_req) begin
                    state_n_s = ST_PEND;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!swap_req) begin
                    state_n_s = ST_IDLE;
                end else if (vb_rise_s) begin
                    state_n_s = ST_ACK;
                    toggle_s  = 1'b1;
                end else begin
                    state_n_s = ST_PEND;
                end
            end
            ST_ACK: begin
                if (!swap_req) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_ACK;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                toggle_s  = 1'b0;
            end
        endcase
    end

    // FSM state, bank select and single-clk acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fb_sel_r   <= 1'b0;
            swap_ack_r <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            swap_ack_r <= toggle_s;
            if (toggle_s) begin
                fb_sel_r <= ~fb_sel_r;
            end else begin
                fb_sel_r <= fb_sel_r;
            end
        end
    end

    assign fb_sel   = fb_sel_r;
    assign swap_ack = swap_ack_r;

endmodule

// File: tb/tb_bz_scanout.sv
module tb_bz_scanout;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        Hsync, Vsync, en_r, hBlank, vBlank;
    logic        fb_rd;
    logic [16:0] fb_addr;
    logic        fb_sel;
    logic [3:0]  fb_data;
    logic        swap_req;
    logic        swap_ack;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, vga_hblank, vga_vblank;

    bz_scanout dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .row(row), .col(col),
        .Hsync(Hsync), .Vsync(Vsync), .en_r(en_r), .hBlank(hBlank), .vBlank(vBlank),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_sel(fb_sel), .fb_data(fb_data),
        .swap_req(swap_req), .swap_ack(swap_ack),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_hblank(vga_hblank), .vga_vblank(vga_vblank)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // values sampled inside step()
    logic        rd_s, rd_idle_s, ack0_s, ack1_s, sel0_s;
    logic [16:0] addr_s;
    // sideband inputs of the previous strobe (what the outputs must show next)
    logic        p_hs, p_vs, p_en, p_hb, p_vb;

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        en, hs, vs, hb, vb;
        logic [3:0]  dat;
        logic        exp_rd;
        logic [16:0] exp_addr;
        logic [3:0]  exp_r, exp_g;   // colour shown after this strobe (from previous vector)
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic reset_prev();
        p_hs = 1'b1; p_vs = 1'b1; p_en = 1'b0; p_hb = 1'b1; p_vb = 1'b1;
    endtask

    // One pixel: strobe clk followed by an idle clk. Checks the sideband delay.
    task automatic step(input logic [8:0] r, input logic [9:0] c, input logic en,
                        input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [3:0] d);
        @(negedge clk);
        pix_ce = 1'b1; row = r; col = c; en_r = en;
        Hsync = hs; Vsync = vs; hBlank = hb; vBlank = vb;
        #1;
        rd_s = fb_rd; addr_s = fb_addr;
        @(posedge clk);
        #1;
        ack0_s = swap_ack; sel0_s = fb_sel;
        fb_data = d;
        chk("vga_hs", vga_hs, p_hs);
        chk("vga_vs", vga_vs, p_vs);
        chk("vga_de", vga_de, p_en);
        chk("vga_hblank", vga_hblank, p_hb);
        chk("vga_vblank", vga_vblank, p_vb);
        chk("vga_b", vga_b, 4'h0);
        p_hs = hs; p_vs = vs; p_en = en; p_hb = hb; p_vb = vb;
        @(negedge clk);
        pix_ce = 1'b0;
        #1;
        rd_idle_s = fb_rd;
        chk("fb_rd_idle_clk", rd_idle_s, 1'b0);
        @(posedge clk);
        #1;
        ack1_s = swap_ack;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fb_rd"}, fb_rd, 1'b0);
        chk({tag, "_fb_addr"}, fb_addr, 17'd0);
        chk({tag, "_fb_sel"}, fb_sel, 1'b0);
        chk({tag, "_swap_ack"}, swap_ack, 1'b0);
        chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
        chk({tag, "_side"}, {vga_hs, vga_vs, vga_de, vga_hblank, vga_vblank}, 5'b11011);
    endtask

    initial begin
        rst = 1'b1; pix_ce = 1'b0; row = 9'd0; col = 10'd0;
        Hsync = 1'b1; Vsync = 1'b1; en_r = 1'b0; hBlank = 1'b1; vBlank = 1'b1;
        fb_data = 4'h0; swap_req = 1'b0;
        reset_prev();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven datapath vectors ----------------
        //         row     col      en    hs    vs    hb    vb    dat   rd    addr        r     g
        tbl[0]  = '{9'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 17'd0,     4'h0, 4'h0};
        tbl[1]  = '{9'd0,   10'd1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 17'd0,     4'hA, 4'h0};
        tbl[2]  = '{9'd0,   10'd2,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 17'd1,     4'hA, 4'h0};
        tbl[3]  = '{9'd0,   10'd3,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 17'd1,     4'hA, 4'h0};
        tbl[4]  = '{9'd479, 10'd639, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 17'd76799, 4'hA, 4'h0};
        tbl[5]  = '{9'd120, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 17'd19200, 4'h0, 4'h7};
        tbl[6]  = '{9'd119, 10'd5,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 17'd18882, 4'h0, 4'h5};
        tbl[7]  = '{9'd10,  10'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 17'd18882, 4'h3, 4'h0};
        tbl[8]  = '{9'd10,  10'd101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 17'd18882, 4'h0, 4'h0};
        tbl[9]  = '{9'd200, 10'd300, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 1'b1, 17'd32150, 4'h0, 4'h0};
        tbl[10] = '{9'd1,   10'd639, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 1'b1, 17'd319,   4'h0, 4'hC};
        tbl[11] = '{9'd0,   10'd0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 17'd319,   4'h9, 4'h0};
        tbl[12] = '{9'd0,   10'd2,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 1'b0, 17'd319,   4'h0, 4'h0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].row, tbl[i].col, tbl[i].en, tbl[i].hs, tbl[i].vs,
                 tbl[i].hb, tbl[i].vb, tbl[i].dat);
            chk($sformatf("v%0d_fb_rd", i), rd_s, tbl[i].exp_rd);
            chk($sformatf("v%0d_fb_addr", i), addr_s, tbl[i].exp_addr);
            chk($sformatf("v%0d_vga_r", i), vga_r, tbl[i].exp_r);
            chk($sformatf("v%0d_vga_g", i), vga_g, tbl[i].exp_g);
        end

        // ---------------- reduced free-running frame (16 x 10) ----------------
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 16; x++) begin
                logic hb_v, vb_v;
                hb_v = (x >= 10);
                vb_v = (y >= 7);
                step(9'(y * 2), 10'(x * 2), !hb_v && !vb_v, !(x == 12 || x == 13),
                     !(y == 8), hb_v, vb_v, 4'(x));
                if (hb_v || vb_v) chk("frame_blank_no_rd", rd_s, 1'b0);
            end
        end
        // frame ended with vBlank high

        // ---------------- swap handshake ----------------
        swap_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(9'd4, 10'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
            chk("swap_wait_sel", sel0_s, 1'b0);
            chk("swap_wait_ack", ack0_s, 1'b0);
        end
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("swap1_ack", ack0_s, 1'b1);
        chk("swap1_sel", sel0_s, 1'b1);
        chk("swap1_ack_1clk", ack1_s, 1'b0);
        // request still held across the next frame: no second swap
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("held_req_no_swap_sel", sel0_s, 1'b1);
        chk("held_req_no_swap_ack", ack0_s, 1'b0);
        // drop, then re-raise during vBlank: wait for the following frame
        swap_req = 1'b0;
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        swap_req = 1'b1;
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("reraise_in_vblank_sel", sel0_s, 1'b1);
        chk("reraise_in_vblank_ack", ack0_s, 1'b0);
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        chk("reraise_active_sel", sel0_s, 1'b1);
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("swap2_ack", ack0_s, 1'b1);
        chk("swap2_sel", sel0_s, 1'b0);
        chk("swap2_ack_1clk", ack1_s, 1'b0);
        // request withdrawn while pending: no toggle
        swap_req = 1'b0;
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        swap_req = 1'b1;
        step(9'd2, 10'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        swap_req = 1'b0;
        step(9'd2, 10'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
        step(9'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("withdrawn_sel", sel0_s, 1'b0);
        chk("withdrawn_ack", ack0_s, 1'b0);

        // ---------------- reset mid-line with swap pending ----------------
        swap_req = 1'b1;
        step(9'd2, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8);
        step(9'd2, 10'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8);
        chk("pre_reset_r", vga_r, 4'h8);
        @(negedge clk);
        pix_ce = 1'b1; row = 9'd100; col = 10'd100; en_r = 1'b1;
        Hsync = 1'b0; Vsync = 1'b0; hBlank = 1'b0; vBlank = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk);
        #1;
        chk_reset_vals("held_reset");
        @(negedge clk);
        pix_ce = 1'b0;
        rst = 1'b0;
        reset_prev();
        step(9'd2, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h4);
        chk("post_reset_sel", sel0_s, 1'b0);
        chk("post_reset_ack", ack0_s, 1'b0);
        step(9'd2, 10'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h4);
        chk("refill_r", vga_r, 4'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
